// File: rtl/auto_nav_ctrl.sv
// auto_nav_ctrl: wall-following navigation FSM with synchronised/debounced obstacle sensors, optional turn watchdog (AUTO_NAV_WATCHDOG_EN)
// ports: clk_ms/rst_n (1 kHz clock, async active-low reset), auto_en, det_front/det_left/det_right (async, 1 = wall),
//        finish_turning (executor idle/done) -> is_turning, turn_dir (00 straight, 01 left, 10 right, 11 U-turn),
//        moving_fwd, state_o (IDLE=0 FWD=1 DECIDE=2 TURN=3 SETTLE=4 FAULT=5), fault (watchdog tripped)
module auto_nav_ctrl #(
  parameter int SETTLE_MS   = 200,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic       auto_en,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       finish_turning,
  output logic       is_turning,
  output logic [1:0] turn_dir,
  output logic       moving_fwd,
  output logic [2:0] state_o,
  output logic       fault
);
  typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, DECIDE = 3'd2, TURN = 3'd3, SETTLE = 3'd4, FAULT = 3'd5} state_t;
  localparam int SW = $clog2(SETTLE_MS + 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  state_t state, state_n;
  // sensor vectors are {left, front, right}
  logic [2:0] s1, s2, sp, deb;
  logic deb_ok;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] st_cnt;
  logic armed, done, wd_trip;
  logic [1:0] turns_left, dir_n;
  assign done = armed && finish_turning;
  assign dir_n = !deb[0] ? 2'b10 : !deb[1] ? 2'b00 : !deb[2] ? 2'b01 : 2'b11;
  assign is_turning = state == TURN && !done;
  assign moving_fwd = state == FWD || state == SETTLE;
  assign state_o = state;
`ifdef AUTO_NAV_WATCHDOG_EN
  logic [10:0] wd;
  assign wd_trip = wd == 11'h7FF;
  assign fault = state == FAULT;
  always_ff @(posedge clk_ms or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= (state != TURN || done) ? '0 : wd_trip ? wd : wd + 11'd1;
`else
  assign wd_trip = 1'b0;
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk_ms or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // FWD ignores deb until the debouncer has accepted its first vector, so the cleared 000 is never acted upon
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = auto_en ? FWD : IDLE;
      FWD:     state_n = !auto_en ? IDLE : (deb_ok && (deb[1] || !deb[2] || !deb[0])) ? DECIDE : FWD;
      DECIDE:  state_n = !auto_en ? IDLE : dir_n == 2'b00 ? SETTLE : TURN;
      TURN:    state_n = (done && turns_left <= 2'd1) ? (auto_en ? SETTLE : IDLE) : (!done && wd_trip) ? FAULT : TURN;
      SETTLE:  state_n = !auto_en ? IDLE : st_cnt == SW'(SETTLE_MS - 1) ? FWD : SETTLE;
      FAULT:   state_n = auto_en ? FAULT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_ms or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      sp <= '0;
      deb <= '0;
      deb_ok <= 1'b0;
      db_cnt <= '0;
      st_cnt <= '0;
      armed <= 1'b0;
      turns_left <= '0;
      turn_dir <= '0;
    end else begin
      s1 <= {det_left, det_front, det_right};
      s2 <= s1;
      sp <= s2;
      if ((state == SETTLE && state_n != SETTLE) || s2 != sp || (s2 == deb && deb_ok)) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
        deb <= s2;
        deb_ok <= 1'b1;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
      st_cnt <= state != SETTLE ? '0 : st_cnt == SW'(SETTLE_MS) ? st_cnt : st_cnt + 1'b1;
      armed <= state == TURN && !done && (armed || !finish_turning);
      turns_left <= state == DECIDE ? (dir_n == 2'b11 ? 2'd2 : 2'd1) :
                    (state == TURN && done && turns_left > 2'd1) ? turns_left - 2'd1 : turns_left;
      turn_dir <= (state_n == FWD || state_n == IDLE) ? 2'b00 : state == DECIDE ? dir_n : turn_dir;
    end
endmodule
